// File: rtl/demux4_reg.sv
// Four-way registered demultiplexer: one input stream routed by select into
// four one-entry output buffers, each with its own valid/ack handshake.

module demux4_reg_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load wins over a same-cycle ack, so refill happens without a bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ack_i;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

module demux4_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [7:0]       accept_cnt
);
    logic [3:0][WIDTH-1:0] ch_data;
    logic [3:0]            load;
    logic                  xfer;
    logic [7:0]            accept_cnt_q, accept_cnt_d;

    assign in_ready = ~out_valid[select] | out_ack[select];
    assign xfer     = in_valid & in_ready;

    always_comb begin
        load         = '0;
        accept_cnt_d = accept_cnt_q;
        if (xfer) begin
            load[select] = 1'b1;
            accept_cnt_d = accept_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) accept_cnt_q <= '0;
        else        accept_cnt_q <= accept_cnt_d;
    end

    for (genvar n = 0; n < 4; n++) begin : g_ch
        demux4_reg_chan #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[n]),
            .ack_i   (out_ack[n]),
            .data_i  (in_data),
            .data_o  (ch_data[n]),
            .valid_o (out_valid[n])
        );
    end

    assign out1       = ch_data[0];
    assign out2       = ch_data[1];
    assign out3       = ch_data[2];
    assign out4       = ch_data[3];
    assign accept_cnt = accept_cnt_q;
endmodule
